// File: rtl/vga_text_pkg.sv
// Shared constants for the character-cell VGA engine: attribute word layout,
// border colour and a constant clog2 used for port and counter widths.
package vga_text_pkg;

  localparam int ATTR_W     = 32;
  localparam int FG_LSB     = 0;
  localparam int FG_MSB     = 8;
  localparam int BG_LSB     = 9;
  localparam int BG_MSB     = 17;
  localparam int BLINK_BIT  = 18;
  localparam int BORDER_BIT = 19;
  localparam int GLYPH_LSB  = 24;
  localparam int GLYPH_MSB  = 30;

  localparam logic [ATTR_W-1:0] BORDER_COLOR = '1;

  // Never returns less than 1 so single-entry dimensions still get a real bit.
  function automatic int vt_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/vga_attr_ram.sv
// Per-cell attribute store: one synchronous write port, one registered read
// port; a same-cycle write to the read cell returns the previous word.
module vga_attr_ram
  import vga_text_pkg::*;
#(
  parameter int COLS = 32,
  parameter int ROWS = 12
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [vt_clog2(ROWS)-1:0] wr_row,
  input  logic [vt_clog2(COLS)-1:0] wr_col,
  input  logic [ATTR_W-1:0]         wr_data,
  input  logic [vt_clog2(ROWS)-1:0] rd_row,
  input  logic [vt_clog2(COLS)-1:0] rd_col,
  output logic [ATTR_W-1:0]         rd_data
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = vt_clog2(DEPTH);

  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Out-of-range coordinates would alias onto other cells, so they are dropped.
  assign wr_ok   = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign wr_addr = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_addr = AW'(int'(rd_row) * COLS + int'(rd_col));

  genvar gi;
  generate
    for (gi = 0; gi < ATTR_W / 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data[gi*8 +: 8];
        q_reg <= mem[rd_addr];
      end

      assign rd_data[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/vga_text_engine.sv
// Character-cell text renderer: walks the visible pixel stream, looks up the
// cell attribute, drives the font ROM and resolves the final pixel colour.
module vga_text_engine
  import vga_text_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int ROWS       = 12,
  parameter int CELL_W     = 25,
  parameter int CELL_H     = 50,
  parameter int COLOR_W    = 9,
  parameter int FONT_AW    = 11,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pix_en,
  input  logic                      wr_en,
  input  logic [vt_clog2(ROWS)-1:0] wr_row,
  input  logic [vt_clog2(COLS)-1:0] wr_col,
  input  logic [ATTR_W-1:0]         wr_data,
  input  logic                      cur_en,
  input  logic [vt_clog2(ROWS)-1:0] cur_row,
  input  logic [vt_clog2(COLS)-1:0] cur_col,
  output logic [6:0]                font_glyph,
  output logic [FONT_AW-1:0]        font_addr,
  input  logic                      font_bit,
  output logic                      pix_valid,
  output logic [COLOR_W-1:0]        pix_color,
  output logic                      frame_done
);

  localparam int PXW = vt_clog2(CELL_W);
  localparam int PYW = vt_clog2(CELL_H);
  localparam int CW  = vt_clog2(COLS);
  localparam int RW  = vt_clog2(ROWS);

  logic [PXW-1:0] px_reg, px_next, px_eff;
  logic [PYW-1:0] py_reg, py_next, py_eff;
  logic [CW-1:0]  col_reg, col_next, col_eff;
  logic [RW-1:0]  row_reg, row_next, row_eff;
  logic           px_end, py_end, col_end, row_end;
  logic           edge_now, hit_now, last_now;
  logic [FONT_AW-1:0] addr_now;

  logic [BLINK_LOG2:0] frame_cnt_reg, frame_cnt_next;

  logic [ATTR_W-1:0] rd_data;

  logic               s1_valid_reg, s1_edge_reg, s1_hit_reg, s1_last_reg, s1_phase_reg;
  logic [FONT_AW-1:0] font_addr_reg;

  logic               s2_valid_reg, s2_edge_reg, s2_hit_reg, s2_last_reg;
  logic               s2_blink_reg, s2_border_reg;
  logic [COLOR_W-1:0] s2_fg_reg, s2_bg_reg;

  logic [COLOR_W-1:0] fg_sel, bg_sel, color_next;
  logic [COLOR_W-1:0] pix_color_reg;
  logic               pix_valid_reg, frame_done_reg;
  logic               attr_unused;

  // A frame_start pixel is treated as the first pixel of the new frame.
  always_comb begin
    px_eff  = frame_start ? '0 : px_reg;
    py_eff  = frame_start ? '0 : py_reg;
    col_eff = frame_start ? '0 : col_reg;
    row_eff = frame_start ? '0 : row_reg;

    px_end  = (px_eff  == PXW'(CELL_W - 1));
    py_end  = (py_eff  == PYW'(CELL_H - 1));
    col_end = (col_eff == CW'(COLS - 1));
    row_end = (row_eff == RW'(ROWS - 1));

    px_next  = px_eff;
    py_next  = py_eff;
    col_next = col_eff;
    row_next = row_eff;
    if (pix_en) begin
      if (!px_end) begin
        px_next = px_eff + PXW'(1);
      end else begin
        px_next = '0;
        if (!col_end) begin
          col_next = col_eff + CW'(1);
        end else begin
          col_next = '0;
          if (!py_end) begin
            py_next = py_eff + PYW'(1);
          end else begin
            py_next  = '0;
            row_next = row_end ? '0 : row_eff + RW'(1);
          end
        end
      end
    end

    edge_now = px_end || py_end || (px_eff == '0) || (py_eff == '0);
    hit_now  = cur_en && (row_eff == cur_row) && (col_eff == cur_col);
    last_now = px_end && col_end && py_end && row_end;
    addr_now = edge_now ? '0
             : FONT_AW'((int'(px_eff) - 1) + (CELL_W - 2) * (int'(py_eff) - 1));

    frame_cnt_next = frame_cnt_reg + {{BLINK_LOG2{1'b0}}, frame_start};
  end

  vga_attr_ram #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_attr_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (row_eff),
    .rd_col  (col_eff),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      px_reg        <= '0;
      py_reg        <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      frame_cnt_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_edge_reg   <= 1'b0;
      s1_hit_reg    <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_phase_reg  <= 1'b0;
      font_addr_reg <= '0;
      s2_valid_reg  <= 1'b0;
      s2_edge_reg   <= 1'b0;
      s2_hit_reg    <= 1'b0;
      s2_last_reg   <= 1'b0;
      s2_blink_reg  <= 1'b0;
      s2_border_reg <= 1'b0;
      s2_fg_reg     <= '0;
      s2_bg_reg     <= '0;
      pix_valid_reg <= 1'b0;
      pix_color_reg <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      px_reg        <= px_next;
      py_reg        <= py_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      frame_cnt_reg <= frame_cnt_next;

      s1_valid_reg <= pix_en;
      s1_edge_reg  <= edge_now;
      s1_hit_reg   <= hit_now;
      s1_last_reg  <= pix_en && last_now;
      // Phase is captured with the pixel so a frame_start in flight cannot flip it.
      s1_phase_reg <= frame_cnt_next[BLINK_LOG2];
      if (pix_en) font_addr_reg <= addr_now;

      s2_valid_reg  <= s1_valid_reg;
      s2_edge_reg   <= s1_edge_reg;
      s2_hit_reg    <= s1_hit_reg;
      s2_last_reg   <= s1_valid_reg && s1_last_reg;
      s2_blink_reg  <= rd_data[BLINK_BIT] && s1_phase_reg;
      s2_border_reg <= rd_data[BORDER_BIT];
      s2_fg_reg     <= COLOR_W'(rd_data[FG_MSB:FG_LSB]);
      s2_bg_reg     <= COLOR_W'(rd_data[BG_MSB:BG_LSB]);

      pix_valid_reg  <= s2_valid_reg;
      pix_color_reg  <= color_next;
      frame_done_reg <= s2_valid_reg && s2_last_reg;
    end
  end

  // The cursor swap does not reach the edge ring, which uses the stored bg.
  always_comb begin
    fg_sel     = s2_hit_reg ? s2_bg_reg : s2_fg_reg;
    bg_sel     = s2_hit_reg ? s2_fg_reg : s2_bg_reg;
    color_next = '0;
    if (s2_valid_reg) begin
      if (s2_edge_reg)       color_next = s2_border_reg ? COLOR_W'(BORDER_COLOR) : s2_bg_reg;
      else if (s2_blink_reg) color_next = bg_sel;
      else                   color_next = font_bit ? fg_sel : bg_sel;
    end
  end

  assign font_glyph  = s1_valid_reg ? rd_data[GLYPH_MSB:GLYPH_LSB] : 7'd0;
  assign font_addr   = font_addr_reg;
  assign pix_valid   = pix_valid_reg;
  assign pix_color   = pix_color_reg;
  assign frame_done  = frame_done_reg;
  assign attr_unused = ^{rd_data[23:20], rd_data[31]};

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a reduced 5x3 grid of 25x10 cells.
module tb_vga_text_engine;

  localparam int COLS = 5, ROWS = 3, CELL_W = 25, CELL_H = 10;
  localparam int LINE  = COLS * CELL_W;
  localparam int CROW  = LINE * CELL_H;
  localparam int FRAME = CROW * ROWS;

  logic        clk = 1'b0;
  logic        rst, frame_start, pix_en, wr_en, cur_en, font_bit, font_ret;
  logic [1:0]  wr_row, cur_row;
  logic [2:0]  wr_col, cur_col;
  logic [31:0] wr_data;
  logic [6:0]  font_glyph;
  logic [10:0] font_addr;
  logic        pix_valid, frame_done;
  logic [8:0]  pix_color;

  int vec_cnt = 0, err_cnt = 0;
  logic mon = 1'b0;
  int nvalid = 0, ndone = 0, done_at = -1;

  vga_text_engine #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .COLOR_W(9), .FONT_AW(11), .BLINK_LOG2(5)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_en(pix_en),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cur_en(cur_en), .cur_row(cur_row), .cur_col(cur_col),
    .font_glyph(font_glyph), .font_addr(font_addr), .font_bit(font_bit),
    .pix_valid(pix_valid), .pix_color(pix_color), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Font ROM stand-in: returns the selected bit one clock after the address.
  always @(posedge clk) font_bit <= font_ret;

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon) begin
      if (pix_valid) nvalid++;
      if (frame_done) begin
        ndone++;
        done_at = pix_valid ? nvalid : -2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    $display("vec %0d %s observed=%0h expected=%0h", vec_cnt, tag, obs, exp);
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] r, input logic [2:0] c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // New frame, walk n pixels, then idle so the pipeline drains.
  task automatic goto_pix(input int n);
    fstart();
    pix_en = 1'b1;
    repeat (n) tick();
    pix_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic one_pixel();
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
  endtask

  task automatic expect_color(input string tag, input logic [8:0] exp);
    one_pixel();
    tick();
    tick();
    chk({tag, "_valid"}, 32'(pix_valid), 32'd1);
    chk(tag, 32'(pix_color), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_en = 1'b0; wr_en = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    cur_en = 1'b0; cur_row = '0; cur_col = '0; font_ret = 1'b0;
    tick(); tick();
    chk("rst_glyph", 32'(font_glyph), 32'd0);
    chk("rst_addr", 32'(font_addr), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    write(2'd0, 3'd0, 32'h410001FF);  // glyph 41, fg 1FF, bg 0
    write(2'd2, 3'd3, 32'h120986AA);  // border on, fg 0AA, bg 0C3
    write(2'd1, 3'd1, 32'h20038007);  // fg 007, bg 1C0
    write(2'd1, 3'd0, 32'h00000015);  // fg 015, bg 0
    write(2'd0, 3'd1, 32'h33040A38);  // blink, fg 038, bg 005

    // Cell (0,0), py=2 px=5, with a 3-cycle latency check.
    goto_pix(2 * LINE + 5);
    font_ret = 1'b1;
    one_pixel();
    chk("t1_glyph", 32'(font_glyph), 32'h41);
    chk("t1_addr", 32'(font_addr), 32'd27);
    chk("t1_valid_t1", 32'(pix_valid), 32'd0);
    tick();
    chk("t1_valid_t2", 32'(pix_valid), 32'd0);
    tick();
    chk("t1_valid_t3", 32'(pix_valid), 32'd1);
    chk("t1_color", 32'(pix_color), 32'h1FF);
    tick();
    chk("t1_idle_valid", 32'(pix_valid), 32'd0);
    chk("t1_idle_color", 32'(pix_color), 32'd0);

    // Cell (2,3), left border column on an interior line.
    goto_pix(2 * CROW + 3 * LINE + 3 * CELL_W);
    one_pixel();
    chk("t2_edge_addr", 32'(font_addr), 32'd0);
    tick(); tick();
    chk("t2_border_on", 32'(pix_color), 32'h1FF);
    write(2'd2, 3'd3, 32'h12F186AA);  // border off, reserved bits set
    goto_pix(2 * CROW + 3 * LINE + 3 * CELL_W);
    expect_color("t2_border_off", 9'h0C3);

    // Cursor on (1,1); neighbour (1,0) must not swap.
    cur_en = 1'b1; cur_row = 2'd1; cur_col = 3'd1;
    font_ret = 1'b1;
    goto_pix(CROW + 4 * LINE + CELL_W + 10);
    expect_color("t3_cur_bit1", 9'h1C0);
    font_ret = 1'b0;
    goto_pix(CROW + 4 * LINE + CELL_W + 10);
    expect_color("t3_cur_bit0", 9'h007);

    // Out-of-range writes must not land anywhere (col 5 would alias (1,0)).
    write(2'd0, 3'd5, 32'hFFFFFFFF);
    write(2'd3, 3'd0, 32'hFFFFFFFF);
    font_ret = 1'b1;
    goto_pix(CROW + 4 * LINE + 10);
    expect_color("t5_noalias", 9'h015);
    cur_en = 1'b0;

    // Blink: frame counter restarts from 0 on reset.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (30) fstart();
    goto_pix(LINE + CELL_W + 1);          // frame 31
    expect_color("t4_f31_bit1", 9'h038);
    goto_pix(LINE + CELL_W + 1);          // frame 32
    expect_color("t4_f32_bit1", 9'h005);
    font_ret = 1'b0;
    goto_pix(LINE + CELL_W + 1);          // frame 33
    expect_color("t4_f33_bit0", 9'h005);

    // Whole frame with random gaps.
    fstart();
    mon = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      pix_en = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      one_pixel();
    end
    repeat (4) tick();
    mon = 1'b0;
    chk("t5_nvalid", 32'(nvalid), 32'(FRAME));
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_done_at", 32'(done_at), 32'(FRAME));

    // Counters wrapped to (0,0) without a new frame_start.
    pix_en = 1'b1;
    repeat (2 * LINE + 5) tick();
    pix_en = 1'b0;
    repeat (3) tick();
    one_pixel();
    chk("t5_wrap_addr", 32'(font_addr), 32'd27);
    repeat (3) tick();

    // Reset mid-line kills in-flight pixels in the same clock.
    goto_pix(0);
    pix_en = 1'b1;
    repeat (2 * LINE + 5) tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(pix_valid), 32'd0);
    chk("t6_rst_addr", 32'(font_addr), 32'd0);
    rst = 1'b0; pix_en = 1'b0;
    tick();
    frame_start = 1'b1; pix_en = 1'b1;
    tick();
    frame_start = 1'b0; pix_en = 1'b0;
    chk("t6_first_addr", 32'(font_addr), 32'd0);
    chk("t6_first_glyph", 32'(font_glyph), 32'h41);
    tick(); tick();
    chk("t6_first_color", 32'(pix_color), 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vga_text_engine.md
Name: vga_text_engine

Overview:
- Parametrised successor of the fixed 32x12 VGA character-cell controller.
- Walks the visible pixel stream cell by cell and holds one 32-bit attribute word per cell.
- Drives glyph index and glyph-pixel address to the external font ROM, then produces the final pixel colour.
- New over the fixed controller: configurable grid and cell size, foreground/background colour, per-cell border, per-cell blink, a hardware cursor, and a valid-tagged 3-stage pipeline.

Parameters:
- COLS, 32, character columns per row
- ROWS, 12, character rows per frame
- CELL_W, 25, pixels per cell horizontally, border columns included
- CELL_H, 50, pixel lines per cell, border lines included
- COLOR_W, 9, colour width (3:3:3)
- FONT_AW, 11, font pixel-address width; must satisfy 2^FONT_AW >= (CELL_W-2)*(CELL_H-2)
- BLINK_LOG2, 5, blink phase toggles every 2^BLINK_LOG2 frames

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
- pix_en  in  1  current cycle carries one visible pixel
- wr_en  in  1  attribute write strobe
- wr_row  in  clog2(ROWS)  write row
- wr_col  in  clog2(COLS)  write column
- wr_data  in  32  attribute word
- cur_en  in  1  cursor enable (level)
- cur_row  in  clog2(ROWS)  cursor row
- cur_col  in  clog2(COLS)  cursor column
- font_glyph  out  7  glyph index to font ROM
- font_addr  out  FONT_AW  pixel index within glyph
- font_bit  in  1  font ROM data, one cycle after font_addr
- pix_valid  out  1  pix_color is valid
- pix_color  out  COLOR_W  output pixel colour
- frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
Reset:
- Clears counters, frame counter and all pipeline valids.
- Outputs after reset: font_glyph=0, font_addr=0, pix_valid=0, pix_color=0, frame_done=0.
- Attribute RAM is not reset.

Attribute word fields:
- [8:0] foreground colour
- [17:9] background colour
- [18] blink
- [19] border enable
- [23:20] reserved, ignored
- [30:24] glyph index
- [31] reserved
- Fields wider than COLOR_W are truncated to COLOR_W LSBs.

Write port:
- Registered write on wr_en.
- Writes with wr_row>=ROWS or wr_col>=COLS are ignored.
- A write and a read of the same cell in the same cycle: the read returns the old word.

Counters (px, col, py, row) advance only on pix_en:
- px wraps at CELL_W-1, then col increments.
- col wraps at COLS-1, then py increments.
- py wraps at CELL_H-1, then row increments.
- row wraps at ROWS-1, then frame_done is pulsed with that pixel's pix_valid.
- frame_start forces all four counters to 0. If pix_en is high in the same cycle, that pixel is (0,0,0,0) and px becomes 1.

Pipeline, pixel sampled at cycle t:
- S1 (t+1): attribute read registered; font_glyph = attr[30:24].
  - font_addr = (px-1)+(CELL_W-2)*(py-1) for interior pixels.
  - font_addr = 0 for edge pixels (px==0 | px==CELL_W-1 | py==0 | py==CELL_H-1).
  - Edge flag and cursor-hit flag are registered alongside.
- S2 (t+2): font_bit is sampled.
- S3 (t+3): pix_color and pix_valid are registered. Latency is exactly 3 clocks, independent of pix_en gaps.

Colour select, in priority order:
1. Edge pixel: border enabled gives all ones; border disabled gives bg.
2. Blink set and blink phase = 1: bg.
3. Otherwise: fg when font_bit = 1, bg when font_bit = 0.
4. Cursor hit (cur_en, row==cur_row, col==cur_col) swaps fg and bg before steps 2 and 3.

Frame and blink:
- frame counter increments on each frame_start and wraps freely.
- blink phase = frame counter bit BLINK_LOG2.
- Invalid pipeline slots output pix_color=0.
- rst asserted mid-frame clears everything in the same clock.

Decomposition:
- Package vga_text_pkg holds:
  - attribute field LSB/MSB constants
  - border colour constant (all ones)
  - attribute word width of 32
  - a clog2 helper function
- One sub-module, vga_attr_ram: COLS*ROWS x 32, one synchronous write port and one synchronous read port, read-old-on-collision.
- Counter, pipeline and colour logic stay in the top level.

Test Plan:
- Write cell (0,0) = fg 9'h1FF, bg 0, glyph 7'h41, border off. frame_start then pixel at px=5, py=2 gives font_glyph=7'h41, font_addr=27. Return font_bit=1: pix_color=9'h1FF exactly 3 clocks after pix_en.
- Set border bit on cell (2,3). Pixel px=0 in that cell gives 9'h1FF. The same pixel with border cleared gives the bg value.
- Set cur_en with cursor at (1,1) on a cell with fg=9'h007, bg=9'h1C0. font_bit=1 gives 9'h1C0; font_bit=0 gives 9'h007.
- Blink cell with fg 9'h038. Frames 0–31 follow font_bit; frames 32–63 show bg only.
- Stream COLS*CELL_W*ROWS*CELL_H pixels with random pix_en gaps: frame_done pulses exactly once, on the final pix_valid. Write to row=ROWS: no RAM change.
- Assert rst mid-line: pix_valid=0 on the next clock. Next frame_start plus first pixel gives font_addr=0 at (0,0).
